// File: rtl/writeback_if.sv
// Bundle handshake and register-file write port of the writeback stage.
// The producer side uses master; the stage itself uses slave.
interface writeback_if #(parameter int XLEN = 32);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [2:0]      result_src_i;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] read_data_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] pc_plus_offset_i;
  logic [XLEN-1:0] pc_plus4_i;
  logic [2:0]      funct3_i;
  logic [4:0]      rd_i;
  logic            reg_write_i;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            rf_ready_i;

  modport master (
    output in_valid_i, result_src_i, alu_result_i, read_data_i, imm_i,
           pc_plus_offset_i, pc_plus4_i, funct3_i, rd_i, reg_write_i, rf_ready_i,
    input  in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  in_valid_i, result_src_i, alu_result_i, read_data_i, imm_i,
           pc_plus_offset_i, pc_plus4_i, funct3_i, rd_i, reg_write_i, rf_ready_i,
    output in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: selects and formats the result at accept, holds it in a
// two-entry in-order buffer, drives the register-file write port and forwarding.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  writeback_if.slave       wb,
  input  logic [4:0]       fwd_rs_i,
  output logic             fwd_hit_o,
  output logic [XLEN-1:0]  fwd_data_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic             err_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] data0, data1;
  logic [4:0]      rd0, rd1;
  logic            wen0, wen1;
  logic [CNT_W-1:0] cnt;
  logic            err;

  logic            head_valid, accept, retire;
  logic [2:0]      off;
  logic [XLEN-1:0] sh, ld_data, res;
  logic            ld_err, res_err, new_wen;

  assign head_valid = (state != EMPTY);
  assign accept     = wb.in_valid_i && (state != FULL) && !flush_i;
  assign retire     = head_valid && (!wen0 || wb.rf_ready_i) && !flush_i;
  assign new_wen    = wb.reg_write_i && (wb.rd_i != 5'd0);
  assign off        = (XLEN == 64) ? wb.alu_result_i[2:0] : {1'b0, wb.alu_result_i[1:0]};

  // Shift the addressed lane down to bit 0, then extend; misaligned accesses
  // still format from the naturally aligned lane but flag an error.
  always_comb begin
    sh      = '0;
    ld_data = wb.read_data_i;
    ld_err  = 1'b0;
    case (wb.funct3_i)
      3'b000, 3'b100: begin
        sh = wb.read_data_i >> {off, 3'b000};
        if (wb.funct3_i[2]) ld_data = XLEN'(sh[7:0]);
        else                ld_data = XLEN'($signed(sh[7:0]));
      end
      3'b001, 3'b101: begin
        sh = wb.read_data_i >> {off[2:1], 4'b0000};
        if (wb.funct3_i[2]) ld_data = XLEN'(sh[15:0]);
        else                ld_data = XLEN'($signed(sh[15:0]));
        ld_err = off[0];
      end
      3'b010: begin
        sh      = wb.read_data_i >> {off[2], 5'b00000};
        ld_data = XLEN'($signed(sh[31:0]));
        ld_err  = (off[1:0] != 2'b00);
      end
      3'b110: begin
        if (XLEN == 64) begin
          sh      = wb.read_data_i >> {off[2], 5'b00000};
          ld_data = XLEN'(sh[31:0]);
          ld_err  = (off[1:0] != 2'b00);
        end else begin
          ld_err = 1'b1;
        end
      end
      3'b011: ld_err = (XLEN == 64) ? (off != 3'b000) : 1'b1;
      default: ld_err = 1'b1;
    endcase
  end

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (wb.result_src_i)
      3'd0: res = wb.alu_result_i;
      3'd1: begin
        res     = ld_data;
        res_err = ld_err;
      end
      3'd2: res = wb.imm_i;
      3'd3: res = wb.pc_plus_offset_i;
      3'd4: res = wb.pc_plus4_i;
      default: res_err = 1'b1;
    endcase
  end

  // Entry 0 is always the head; entry 1 is only meaningful in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data0 <= '0;
      data1 <= '0;
      rd0   <= '0;
      rd1   <= '0;
      wen0  <= 1'b0;
      wen1  <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      if (accept && res_err) err <= 1'b1;
      if (retire) cnt <= cnt + 1'b1;
      if (flush_i) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: if (accept) begin
            data0 <= res;
            rd0   <= wb.rd_i;
            wen0  <= new_wen;
            state <= ONE;
          end
          ONE: begin
            if (accept && retire) begin
              data0 <= res;
              rd0   <= wb.rd_i;
              wen0  <= new_wen;
            end else if (accept) begin
              data1 <= res;
              rd1   <= wb.rd_i;
              wen1  <= new_wen;
              state <= FULL;
            end else if (retire) begin
              state <= EMPTY;
            end
          end
          FULL: if (retire) begin
            data0 <= data1;
            rd0   <= rd1;
            wen0  <= wen1;
            state <= ONE;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  logic hit0, hit1;
  assign hit0 = head_valid && wen0 && (rd0 == fwd_rs_i) && (fwd_rs_i != 5'd0);
  assign hit1 = (state == FULL) && wen1 && (rd1 == fwd_rs_i) && (fwd_rs_i != 5'd0);

  assign fwd_hit_o     = hit0 || hit1;
  assign fwd_data_o    = hit1 ? data1 : (hit0 ? data0 : '0);
  assign wb.in_ready_o = (state != FULL);
  assign wb.rf_we_o    = head_valid && wen0;
  assign wb.rf_waddr_o = head_valid ? rd0 : 5'd0;
  assign wb.rf_wdata_o = head_valid ? data0 : '0;
  assign retired_cnt_o = cnt;
  assign err_o         = err;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage (XLEN=32, CNT_W=4) against a queue-based
// reference model, plus directed cases for load formatting, backpressure, flush and reset.
module tb_writeback_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [4:0] fwd_rs;
  logic fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0] retired_cnt;
  logic err;

  writeback_if #(.XLEN(32)) wb ();

  writeback_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .wb(wb),
    .fwd_rs_i(fwd_rs), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .retired_cnt_o(retired_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    bit          wen;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int unsigned m_cnt = 0;
  bit m_err = 1'b0;

  function automatic void model_load(input logic [31:0] w, input logic [31:0] alu,
                                     input logic [2:0] f3, output logic [31:0] v, output bit bad);
    int unsigned off = alu % 4;
    int unsigned b, h;
    bad = 1'b0;
    v = w;
    case (f3)
      3'd0, 3'd4: begin
        b = (w >> (8 * off)) & 32'hFF;
        v = b;
        if (f3 == 3'd0 && b >= 128) v = b + 32'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        v = h;
        if (f3 == 3'd1 && h >= 32768) v = h + 32'hFFFF0000;
        bad = (off % 2) != 0;
      end
      3'd2: bad = (off != 0);
      default: bad = 1'b1;
    endcase
  endfunction

  // One clock of stimulus: compare outputs against the model, clock, update the model.
  task automatic cycle(input bit v, input logic [2:0] src, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] imm, input logic [31:0] pco, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic [4:0] rd, input bit rw,
                       input bit rdy, input bit fl, input logic [4:0] rs, output bit acc);
    bit hv, ret, bad, ehit;
    logic [31:0] res, edata;
    ent_t e;
    wb.in_valid_i = v; wb.result_src_i = src; wb.alu_result_i = alu; wb.read_data_i = rdat;
    wb.imm_i = imm; wb.pc_plus_offset_i = pco; wb.pc_plus4_i = pc4; wb.funct3_i = f3;
    wb.rd_i = rd; wb.reg_write_i = rw; wb.rf_ready_i = rdy; flush = fl; fwd_rs = rs;
    #1;
    hv = q.size() > 0;
    check("in_ready", wb.in_ready_o, q.size() < 2);
    check("rf_we", wb.rf_we_o, hv ? q[0].wen : 1'b0);
    check("rf_waddr", wb.rf_waddr_o, hv ? q[0].rd : 5'd0);
    check("rf_wdata", wb.rf_wdata_o, hv ? q[0].data : 32'd0);
    ehit = 1'b0;
    edata = 32'd0;
    for (int i = 0; i < q.size(); i++)
      if (rs != 0 && q[i].wen && q[i].rd == rs) begin
        ehit = 1'b1;
        edata = q[i].data;
      end
    check("fwd_hit", fwd_hit, ehit);
    check("fwd_data", fwd_data, edata);
    check("retired_cnt", retired_cnt, m_cnt);
    check("err", err, m_err);
    acc = v && q.size() < 2 && !fl;
    ret = hv && (!q[0].wen || rdy) && !fl;
    bad = 1'b0;
    res = 32'd0;
    case (src)
      3'd0: res = alu;
      3'd1: model_load(rdat, alu, f3, res, bad);
      3'd2: res = imm;
      3'd3: res = pco;
      3'd4: res = pc4;
      default: bad = 1'b1;
    endcase
    e.rd = rd;
    e.wen = rw && rd != 0;
    e.data = res;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (ret) m_cnt = (m_cnt + 1) % 16;
    if (acc && bad) m_err = 1'b1;
  endtask

  task automatic idle(input bit rdy, input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, 0, a);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val, input bit rdy, output bit acc);
    cycle(1, 3'd0, val, 0, 0, 0, 0, 3'd0, rd, 1, rdy, 0, 5'd5, acc);
  endtask

  task automatic rnd(input bit clean);
    bit a;
    logic [2:0] src, f3;
    logic [31:0] alu;
    src = clean ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
    alu = $urandom;
    f3 = 3'($urandom_range(0, 7));
    if (clean) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd4;
        2: begin f3 = 3'd1; alu[0] = 1'b0; end
        3: begin f3 = 3'd5; alu[0] = 1'b0; end
        default: begin f3 = 3'd2; alu[1:0] = 2'b00; end
      endcase
    end
    cycle($urandom_range(0, 3) != 0, src, alu, $urandom, $urandom, $urandom, $urandom, f3,
          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 39) == 0, 5'($urandom_range(0, 7)), a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int nacc;
    rst_n = 1'b0;
    flush = 1'b0;
    fwd_rs = 5'd0;
    wb.in_valid_i = 0; wb.result_src_i = 0; wb.alu_result_i = 0; wb.read_data_i = 0;
    wb.imm_i = 0; wb.pc_plus_offset_i = 0; wb.pc_plus4_i = 0; wb.funct3_i = 0;
    wb.rd_i = 0; wb.reg_write_i = 0; wb.rf_ready_i = 0;
    #12;
    check("reset rf_we", wb.rf_we_o, 1'b0);
    check("reset rf_waddr", wb.rf_waddr_o, 5'd0);
    check("reset rf_wdata", wb.rf_wdata_o, 32'd0);
    check("reset fwd_hit", fwd_hit, 1'b0);
    check("reset cnt", retired_cnt, 4'd0);
    check("reset err", err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready after reset", wb.in_ready_o, 1'b1);

    // Load formatting from word 0x80FF7F01
    cycle(1, 3'd1, 32'd1, 32'h80FF7F01, 0, 0, 0, 3'd0, 5'd3, 1, 1, 0, 0, a);
    check("lb off1", wb.rf_wdata_o, 32'h0000007F);
    cycle(1, 3'd1, 32'd3, 32'h80FF7F01, 0, 0, 0, 3'd0, 5'd3, 1, 1, 0, 0, a);
    check("lb off3", wb.rf_wdata_o, 32'hFFFFFF80);
    cycle(1, 3'd1, 32'd2, 32'h80FF7F01, 0, 0, 0, 3'd5, 5'd3, 1, 1, 0, 0, a);
    check("lhu off2", wb.rf_wdata_o, 32'h000080FF);
    idle(1, 2);

    // Backpressure: three valids, only two fit
    nacc = 0;
    alu_op(5'd1, 32'hA1, 0, a); nacc += a;
    alu_op(5'd2, 32'hA2, 0, a); nacc += a;
    alu_op(5'd3, 32'hA3, 0, a); nacc += a;
    check("bp accepted", nacc, 2);
    check("bp in_ready", wb.in_ready_o, 1'b0);
    a = 1'b0;
    for (int i = 0; i < 6 && !a; i++) alu_op(5'd3, 32'hA3, 1, a);
    check("third accepted", a, 1'b1);
    idle(1, 3);

    // rd=0 with reg_write never writes but still retires
    alu_op(5'd0, 32'hDEAD, 1, a);
    alu_op(5'd0, 32'hBEEF, 0, a);
    idle(0, 2);

    // Youngest forwarding match
    alu_op(5'd5, 32'h11, 0, a);
    alu_op(5'd5, 32'h22, 0, a);
    check("fwd hit youngest", fwd_hit, 1'b1);
    check("fwd data youngest", fwd_data, 32'h22);

    // Flush while FULL
    cycle(1, 3'd0, 32'h33, 0, 0, 0, 0, 0, 5'd6, 1, 1, 1, 0, a);
    check("flush empties", wb.in_ready_o, 1'b1);
    check("flush no head", wb.rf_we_o, 1'b0);
    idle(1, 2);

    for (int i = 0; i < 300; i++) rnd(1);

    // Bad select sets sticky error
    cycle(1, 3'd6, 32'h77, 0, 0, 0, 0, 0, 5'd7, 1, 1, 0, 0, a);
    check("bad select data", wb.rf_wdata_o, 32'd0);
    check("bad select err", err, 1'b1);
    for (int i = 0; i < 300; i++) rnd(0);
    check("err sticky", err, 1'b1);

    // Reset with two entries buffered
    idle(1, 3);
    alu_op(5'd9, 32'h99, 0, a);
    alu_op(5'd10, 32'hAA, 0, a);
    fwd_rs = 5'd9;
    rst_n = 1'b0;
    #1;
    check("midreset rf_we", wb.rf_we_o, 1'b0);
    check("midreset waddr", wb.rf_waddr_o, 5'd0);
    check("midreset fwd", fwd_hit, 1'b0);
    check("midreset cnt", retired_cnt, 4'd0);
    check("midreset err", err, 1'b0);
    q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    wb.in_valid_i = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) rnd(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; the only legal values are 32 and 64.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port flush_i, input, 1: synchronous buffer clear.
REQ-006 Port in_valid_i, input, 1: the input bundle is valid this cycle.
REQ-007 Port in_ready_o, output, 1: the stage can accept a bundle.
REQ-008 Port result_src_i, input, 3: result select (0 ALU, 1 load, 2 immediate, 3 PC+offset, 4 PC+4).
REQ-009 Ports alu_result_i, read_data_i, imm_i, pc_plus_offset_i, pc_plus4_i, input, XLEN each: candidate results; read_data_i is the raw aligned memory word.
REQ-010 Port funct3_i, input, 3: load type.
REQ-011 Port rd_i, input, 5: destination register.
REQ-012 Port reg_write_i, input, 1: the instruction writes a register.
REQ-013 Ports rf_we_o (1), rf_waddr_o (5), rf_wdata_o (XLEN), output: register-file write port.
REQ-014 Port rf_ready_i, input, 1: the register-file port grants the write this cycle.
REQ-015 Port fwd_rs_i, input, 5: forwarding lookup address.
REQ-016 Ports fwd_hit_o (1), fwd_data_o (XLEN), output: forwarding result.
REQ-017 Port retired_cnt_o, output, CNT_W: number of retired bundles.
REQ-018 Port err_o, output, 1: sticky error flag.

Function
REQ-019 Accept: a bundle is accepted when in_valid_i && in_ready_o && !flush_i.
REQ-020 Buffer: two-entry FIFO with occupancy states EMPTY, ONE, FULL; in_ready_o = (state != FULL), a registered-state function with no combinational path from rf_ready_i.
REQ-021 Result: the result is selected at accept and stored with rd and wen, where wen = reg_write_i && (rd_i != 0).
REQ-022 Select 5-7: store result 0 and set err_o.
REQ-023 Load formatting (select 1): off = alu_result_i[1:0] for XLEN=32, [2:0] for XLEN=64.
REQ-024 Load types: LB/LBU (000/100) byte at off, sign-/zero-extended; LH/LHU (001/101) halfword at off with bit 0 ignored; LW (010) word at off with the low 2 bits ignored, sign-extended to XLEN.
REQ-025 XLEN=64 only: LWU (110) zero-extended word; LD (011) full doubleword.
REQ-026 Load errors: any other funct3, or LWU/LD with XLEN=32, stores read_data_i unchanged and sets err_o.
REQ-027 Misaligned load (halfword with off[0]=1, word with off[1:0]!=0, doubleword with off!=0): data is formatted per REQ-024/025 and err_o is set.
REQ-028 Latency: an accepted bundle is visible at the head on the next cycle.
REQ-029 Write port: rf_we_o = head valid && head wen; rf_waddr_o and rf_wdata_o are the head fields, and are 0 when the head is invalid.
REQ-030 Retire: the head retires when head valid && (!head wen || rf_ready_i); a bundle with wen=0 retires in the cycle it reaches the head.
REQ-031 Simultaneous accept and retire in state ONE keeps state ONE with the new entry as head.
REQ-032 In state FULL, a retire moves to ONE; no accept occurs that cycle.
REQ-033 Ordering: retirement order equals acceptance order.
REQ-034 Forwarding: fwd_hit_o = 1 when any valid entry with wen=1 has rd == fwd_rs_i and fwd_rs_i != 0; the youngest match supplies fwd_data_o; otherwise fwd_data_o = 0. Combinational.
REQ-035 Counter: retired_cnt_o increments by 1 per retire and wraps from 2^CNT_W-1 to 0.
REQ-036 Flush: flush_i empties the buffer next cycle and drops any concurrent input; the head is not written that cycle (rf_we_o is still shown); the counter and err_o are unaffected.
REQ-037 err_o, once set, holds until reset.

Reset
REQ-038 On rst_n low, immediately: state EMPTY, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fwd_hit_o=0, retired_cnt_o=0, err_o=0; in_ready_o=1 after release.
REQ-039 Reset mid-transfer discards all buffered entries without a write.

Verification
REQ-040 LB from word 0x80FF7F01, off=1 -> rf_wdata_o=0x0000007F; off=3 -> 0xFFFFFF80; LHU off=2 -> 0x000080FF.
REQ-041 rf_ready_i=0 with three back-to-back valids -> two accepted, in_ready_o=0; raise rf_ready_i -> writes retire in order, then the third bundle is accepted.
REQ-042 rd_i=0 with reg_write_i=1 -> rf_we_o never asserted, retired_cnt_o increments.
REQ-043 result_src_i=6 -> stored data 0, err_o=1 held through later good bundles until rst_n low.
REQ-044 Two entries both with rd=5 (data 0x11, then 0x22), fwd_rs_i=5 -> fwd_hit_o=1, fwd_data_o=0x22.
REQ-045 CNT_W=4, 17 retires -> retired_cnt_o=1; flush_i in FULL -> state EMPTY next cycle, count unchanged.
